// File: rtl/cv32e40x_pkg.sv
// ============================================================================
// Module      : cv32e40x_pkg
// Description : Shared types for the iterative divider. Holds the divider
//               opcode, the divider state encoding, the datapath width and
//               a two's-complement magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40x_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        COMP   = 2'd2,
        FINISH = 2'd3
    } div_state_e;

    // Magnitude of x when it is treated as signed, otherwise x unchanged.
    // The result is an unsigned 32-bit value, so |0x80000000| = 0x80000000.
    function automatic logic [DIV_WIDTH-1:0] div_abs(
        input logic [DIV_WIDTH-1:0] x,
        input logic                 is_signed
    );
        if (is_signed && x[DIV_WIDTH-1]) begin
            return ~x + 32'd1;
        end
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40x_div_iter.sv
// ============================================================================
// Module      : cv32e40x_div_iter
// Description : Iterative RV32M divider (DIV/DIVU/REM/REMU). The leading-zero
//               count and the divisor normalisation shift are borrowed from
//               the ALU, so only clz(|b|)+1 restoring iterations are needed.
// Ports       : clk, rst_n              - clock, async active-low reset
//               operator_i/op_a_i/op_b_i - request, sampled at accept
//               valid_i / ready_o       - request handshake (ready in IDLE)
//               kill_i                  - abort any operation in flight
//               result_o/valid_o/ready_i - result handshake (valid in FINISH)
//               alu_*                   - borrowed ALU CLZ and shifter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40x_div_iter
    import cv32e40x_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,

    input  div_opcode_e          operator_i,
    input  logic [31:0]          op_a_i,
    input  logic [31:0]          op_b_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 kill_i,

    output logic [31:0]          result_o,
    output logic                 valid_o,
    input  logic                 ready_i,

    output logic                 alu_clz_en_o,
    output logic [31:0]          alu_clz_data_o,
    input  logic [5:0]           alu_clz_result_i,
    output logic                 alu_shift_en_o,
    output logic [5:0]           alu_shift_amt_o,
    output logic [31:0]          alu_op_a_o,
    input  logic [31:0]          alu_op_a_shifted_i
);

    div_state_e    state_q, state_d;
    div_opcode_e   op_q, op_d;
    logic [31:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d;
    logic [31:0]   div_q, div_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          neg_quot_q, neg_quot_d;
    logic          neg_rem_q, neg_rem_d;

    logic          w_signed;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic          w_b_zero;
    logic          w_geq;
    logic [31:0]   w_diff;
    logic          w_is_rem;

    assign w_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
    assign w_abs_a  = div_abs(op_a_i, w_signed);
    assign w_abs_b  = div_abs(op_b_i, w_signed);
    assign w_b_zero = (op_b_i == 32'd0);
    assign w_geq    = (rem_q >= div_q);
    assign w_diff   = rem_q - div_q;
    assign w_is_rem = (op_q == DIV_REM) || (op_q == DIV_REMU);

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        rem_d           = rem_q;
        quo_d           = quo_q;
        div_d           = div_q;
        cnt_d           = cnt_q;
        neg_quot_d      = neg_quot_q;
        neg_rem_d       = neg_rem_q;

        ready_o         = 1'b0;
        valid_o         = 1'b0;
        result_o        = 32'd0;
        alu_clz_en_o    = 1'b0;
        alu_clz_data_o  = 32'd0;
        alu_shift_en_o  = 1'b0;
        alu_shift_amt_o = 6'd0;
        alu_op_a_o      = 32'd0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    op_d = operator_i;
                    if (w_b_zero) begin
                        // Divide by zero: preload the architectural results
                        // and clear the sign flags so FINISH passes them
                        // through untouched (remainder is the raw dividend).
                        rem_d      = op_a_i;
                        quo_d      = 32'hFFFF_FFFF;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FINISH;
                    end else begin
                        rem_d      = w_abs_a;
                        quo_d      = 32'd0;
                        div_d      = w_abs_b;
                        neg_quot_d = w_signed & (op_a_i[31] ^ op_b_i[31]);
                        neg_rem_d  = w_signed & op_a_i[31];
                        state_d    = INIT;
                    end
                end
            end

            INIT: begin
                // |b| was parked in div_q at accept; normalise it so its
                // leading one lands at bit 31.
                alu_clz_en_o    = 1'b1;
                alu_clz_data_o  = div_q;
                alu_shift_en_o  = 1'b1;
                alu_shift_amt_o = alu_clz_result_i;
                alu_op_a_o      = div_q;
                div_d           = alu_op_a_shifted_i;
                cnt_d           = alu_clz_result_i[4:0];
                state_d         = COMP;
            end

            COMP: begin
                if (w_geq) begin
                    rem_d = w_diff;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    quo_d = {quo_q[30:0], 1'b0};
                end
                div_d = div_q >> 1;
                if (cnt_q == 5'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            FINISH: begin
                valid_o = 1'b1;
                if (w_is_rem) begin
                    result_o = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
                end else begin
                    result_o = neg_quot_q ? (~quo_q + 32'd1) : quo_q;
                end
                if (ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= DIV_DIV;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            div_q      <= 32'd0;
            cnt_q      <= 5'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_div_iter.sv
// ============================================================================
// Module      : tb_cv32e40x_div_iter
// Description : Self-checking bench for cv32e40x_div_iter with a behavioural
//               ALU CLZ/shifter, a vector table, a result scoreboard and
//               directed kill / back-pressure / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40x_div_iter;
    import cv32e40x_pkg::*;

    logic         clk;
    logic         rst_n;
    div_opcode_e  operator_i;
    logic [31:0]  op_a_i;
    logic [31:0]  op_b_i;
    logic         valid_i;
    logic         ready_o;
    logic         kill_i;
    logic [31:0]  result_o;
    logic         valid_o;
    logic         ready_i;
    logic         alu_clz_en_o;
    logic [31:0]  alu_clz_data_o;
    logic [5:0]   alu_clz_result_i;
    logic         alu_shift_en_o;
    logic [5:0]   alu_shift_amt_o;
    logic [31:0]  alu_op_a_o;
    logic [31:0]  alu_op_a_shifted_i;

    cv32e40x_div_iter u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .operator_i         (operator_i),
        .op_a_i             (op_a_i),
        .op_b_i             (op_b_i),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .kill_i             (kill_i),
        .result_o           (result_o),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .alu_clz_en_o       (alu_clz_en_o),
        .alu_clz_data_o     (alu_clz_data_o),
        .alu_clz_result_i   (alu_clz_result_i),
        .alu_shift_en_o     (alu_shift_en_o),
        .alu_shift_amt_o    (alu_shift_amt_o),
        .alu_op_a_o         (alu_op_a_o),
        .alu_op_a_shifted_i (alu_op_a_shifted_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU's divider-side CLZ and shifter.
    always_comb begin
        alu_clz_result_i = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (alu_clz_data_o[i]) alu_clz_result_i = 6'(31 - i);
        end
        alu_op_a_shifted_i = alu_op_a_o << alu_shift_amt_o[4:0];
    end

    // ALU-port monitor: outputs must be zero whenever the CLZ enable is low,
    // and both enables always move together.
    int alu_en_cycles = 0;
    int alu_bad       = 0;
    always @(negedge clk) begin
        if (alu_clz_en_o) alu_en_cycles++;
        if ((alu_clz_en_o != alu_shift_en_o) ||
            (!alu_clz_en_o && (alu_clz_data_o != 32'd0 || alu_shift_amt_o != 6'd0 ||
                               alu_op_a_o != 32'd0))) alu_bad++;
    end

    typedef struct {
        div_opcode_e op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
        bit          alu_used;
        int          alu_base;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; the request is accepted on the next edge
    // and the task returns #1 after that accept edge.
    task automatic start(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        exp_t e;
        int   g;
        g = 0;
        while (!ready_o && g < 100) begin
            @(posedge clk); #1; g++;
        end
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        valid_i    = 1'b1;
        e.res      = res;
        e.lat      = lat;
        e.alu_used = (b != 32'd0);
        e.alu_base = alu_en_cycles;
        @(posedge clk); #1;
        valid_i    = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_result(input string name);
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = 1;
        while (!valid_o && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        if (!valid_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: valid_o low after %0d cycles, expected at %0d", name, lat, e.lat);
        end else begin
            check({name, "_res"}, result_o, e.res);
            check({name, "_lat"}, 32'(lat), 32'(e.lat));
            check({name, "_alu"}, 32'(alu_en_cycles != e.alu_base), 32'(e.alu_used));
        end
        if (ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    int vc;

    initial begin
        rst_n      = 1'b0;
        operator_i = DIV_DIVU;
        op_a_i     = 32'd0;
        op_b_i     = 32'd0;
        valid_i    = 1'b0;
        kill_i     = 1'b0;
        ready_i    = 1'b1;

        vecs[0]  = '{DIV_DIVU, 32'd100,        32'd7,          32'd14,         32};
        vecs[1]  = '{DIV_REMU, 32'd100,        32'd7,          32'd2,          32};
        vecs[2]  = '{DIV_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vecs[3]  = '{DIV_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[4]  = '{DIV_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{DIV_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{DIV_REM,  32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{DIV_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[8]  = '{DIV_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[9]  = '{DIV_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[10] = '{DIV_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[11] = '{DIV_DIVU, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          3};
        vecs[12] = '{DIV_REMU, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  3};
        vecs[13] = '{DIV_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[14] = '{DIV_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32};
        vecs[15] = '{DIV_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32};
        vecs[16] = '{DIV_REMU, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        vecs[17] = '{DIV_DIVU, 32'd12345678,   32'd1000,       32'd12345,      25};

        // Reset values while reset is held.
        #3;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_alu_en", 32'({alu_clz_en_o, alu_shift_en_o}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            wait_result($sformatf("vec%0d", i));
        end

        // Kill in the third COMP cycle of DIVU 100/7.
        start(DIV_DIVU, 32'd100, 32'd7, 32'd14, 32);
        repeat (3) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        void'(sb.pop_front());
        check("kill_idle_ready", 32'(ready_o), 32'd1);
        vc = 0;
        repeat (40) begin
            if (valid_o) vc++;
            @(posedge clk); #1;
        end
        check("kill_no_valid", 32'(vc), 32'd0);
        start(DIV_DIVU, 32'd9, 32'd3, 32'd3, 33);
        wait_result("post_kill");

        // Back-pressure in FINISH, then a back-to-back request.
        ready_i = 1'b0;
        start(DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        wait_result("hold");
        vc = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!valid_o || result_o !== 32'hFFFF_FFFD) vc++;
        end
        check("hold_stable", 32'(vc), 32'd0);
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("hold_released", 32'(valid_o), 32'd0);
        start(DIV_REMU, 32'd100, 32'd7, 32'd2, 32);
        wait_result("b2b");

        // Asynchronous reset mid-operation.
        start(DIV_DIVU, 32'd100, 32'd7, 32'd14, 32);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        check("arst_ready", 32'(ready_o), 32'd1);
        check("arst_valid", 32'(valid_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        start(DIV_DIVU, 32'd100, 32'd7, 32'd14, 32);
        wait_result("post_rst");

        check("alu_idle_zero", 32'(alu_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
